// File: rtl/exec_sequencer.sv
// exec_sequencer: run/halt/single-step controller for the 4-bit-PC, 8-bit core.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready    host command handshake; a command is accepted on a rising
//                      edge with cmd_valid & cmd_ready, and cmd_ready is low in STEP
//   cmd_op, cmd_arg    00 HALT, 01 RUN, 10 STEP (arg = cycles, 0 means 1),
//                      11 SET_BP (arg = breakpoint address)
//   pc_addr            current PC of the core
//   core_en            combinational execute enable for the instruction at pc_addr
//   halted, state      halted=1 in HALT/BRK; state 00 HALT 01 RUN 10 STEP 11 BRK
//   bp_hit             a breakpoint stop occurred; cleared when BRK is left
//   retired            count of core_en=1 cycles, wrapping
//
// Build option: define BREAKPOINT_EN to include the breakpoint logic and the BRK
// state. Without it, SET_BP is accepted as a no-op and bp_hit is tied low.
module exec_sequencer #(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [PC_W-1:0]  cmd_arg,
  input  logic [PC_W-1:0]  pc_addr,
  output logic             core_en,
  output logic             halted,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  localparam logic [1:0] OP_HALT   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_SET_BP = 2'b11;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             accept;
  logic             active;
  logic             match;

`ifdef BREAKPOINT_EN
  logic             bp_valid_q, bp_valid_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic             skip_q, skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic             brk_stop;

  // skip masks the match for the single instruction re-executed after BRK.
  assign match  = bp_valid_q & (pc_addr == bp_addr_q) & ~skip_q;
  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;

  assign unused_pc = ^pc_addr;
  assign match     = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign cmd_ready = (state_q != ST_STEP);
  assign accept    = cmd_valid & cmd_ready;
  assign active    = (state_q == ST_RUN) | (state_q == ST_STEP);
  assign core_en   = active & ~match;
  assign halted    = (state_q == ST_HALT) | (state_q == ST_BRK);
  assign state     = state_q;
  assign retired   = retired_q;

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    retired_d  = retired_q;
`ifdef BREAKPOINT_EN
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    skip_d     = skip_q;
    brk_stop   = active & match & ~accept;
`endif

    if (core_en) begin
      retired_d = retired_q + CNT_W'(1);
`ifdef BREAKPOINT_EN
      skip_d = 1'b0;
`endif
      if (state_q == ST_STEP) begin
        step_cnt_d = step_cnt_q - PC_W'(1);
        if (step_cnt_q == PC_W'(1)) state_d = ST_HALT;
      end
    end

`ifdef BREAKPOINT_EN
    if (brk_stop) begin
      state_d    = ST_BRK;
      step_cnt_d = '0;
    end
`endif

    // An accepted command overrides a breakpoint stop in the same cycle.
    if (accept) begin
      unique case (cmd_op)
        OP_HALT: state_d = ST_HALT;
        OP_RUN: begin
          state_d = ST_RUN;
`ifdef BREAKPOINT_EN
          if (state_q == ST_BRK) skip_d = 1'b1;
`endif
        end
        OP_STEP: begin
          state_d    = ST_STEP;
          step_cnt_d = (cmd_arg == '0) ? PC_W'(1) : cmd_arg;
`ifdef BREAKPOINT_EN
          if (state_q == ST_BRK) skip_d = 1'b1;
`endif
        end
        OP_SET_BP: begin
`ifdef BREAKPOINT_EN
          bp_valid_d = 1'b1;
          bp_addr_d  = cmd_arg;
`endif
        end
        default: ;
      endcase
    end

`ifdef BREAKPOINT_EN
    bp_hit_d = brk_stop | (bp_hit_q & (state_d == ST_BRK));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_HALT;
      step_cnt_q <= '0;
      retired_q  <= '0;
`ifdef BREAKPOINT_EN
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      retired_q  <= retired_d;
`ifdef BREAKPOINT_EN
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
`endif
    end
  end

endmodule
